// File: rtl/coarse_tile_scheduler_if.sv
// Shade-request / shade-result / pixel-write bundle for the coarse tile scheduler.
// master = scheduler side; slave = shader dispatch + tile colour buffer side.
interface coarse_tile_scheduler_if #(
  parameter int COORD_W = 8,
  parameter int DATA_W  = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_cen_x;
  logic [COORD_W-1:0] req_cen_y;
  logic [COORD_W-1:0] req_group_id;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;

  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [DATA_W-1:0]  wr_data;

  modport master (
    output req_valid, req_cen_x, req_cen_y, req_group_id,
    input  req_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    output wr_valid, wr_x, wr_y, wr_data,
    input  wr_ready
  );

  modport slave (
    input  req_valid, req_cen_x, req_cen_y, req_group_id,
    output req_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    input  wr_valid, wr_x, wr_y, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/coarse_tile_scheduler.sv
// Coarse pixel shading sequencer for one tile: one centroid request per group,
// then the shaded result is broadcast as per-pixel writes over the group.
// Ports: clk, rst (sync, active high), start, rate_log2 (0=1x1,1=2x2,2/3=4x4),
//   busy, done, bus (req/rsp/wr handshakes, master modport).
// Optional: COARSE_SCHED_COVERAGE_EN adds cov_mask (bit y*TILE_W+x, sampled on
//   start); uncovered groups are skipped and uncovered pixels are not written.
module coarse_tile_scheduler #(
  parameter int TILE_W  = 16,
  parameter int TILE_H  = 16,
  parameter int COORD_W = 8,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               rate_log2,
`ifdef COARSE_SCHED_COVERAGE_EN
  input  logic [TILE_W*TILE_H-1:0] cov_mask,
`endif
  output logic                     busy,
  output logic                     done,
  coarse_tile_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Last group index per rate, and groups per row (mod 2^COORD_W).
  localparam logic [COORD_W-1:0] GXM0 = COORD_W'(TILE_W - 1);
  localparam logic [COORD_W-1:0] GXM1 = COORD_W'(TILE_W / 2 - 1);
  localparam logic [COORD_W-1:0] GXM2 = COORD_W'(TILE_W / 4 - 1);
  localparam logic [COORD_W-1:0] GYM0 = COORD_W'(TILE_H - 1);
  localparam logic [COORD_W-1:0] GYM1 = COORD_W'(TILE_H / 2 - 1);
  localparam logic [COORD_W-1:0] GYM2 = COORD_W'(TILE_H / 4 - 1);
  localparam logic [COORD_W-1:0] GPR0 = COORD_W'(TILE_W);
  localparam logic [COORD_W-1:0] GPR1 = COORD_W'(TILE_W / 2);
  localparam logic [COORD_W-1:0] GPR2 = COORD_W'(TILE_W / 4);

  state_t             state_q, state_d;
  logic [1:0]         r_q, r_d;
  logic [COORD_W-1:0] gx_q, gx_d;
  logic [COORD_W-1:0] gy_q, gy_d;
  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [COORD_W-1:0] gx_max;
  logic [COORD_W-1:0] gy_max;
  logic [COORD_W-1:0] gpr;
  logic [COORD_W-1:0] s_max;
  logic [COORD_W-1:0] half;
  logic [COORD_W-1:0] base_x;
  logic [COORD_W-1:0] base_y;
  logic [COORD_W-1:0] gx_nx;
  logic [COORD_W-1:0] gy_nx;
  logic               last_grp;

  logic               grp_cov;
  logic               pix_cov;
  logic               any_cov;

  always_comb begin
    case (r_q)
      2'd0: begin
        gx_max = GXM0;
        gy_max = GYM0;
        gpr    = GPR0;
        s_max  = '0;
        half   = '0;
      end
      2'd1: begin
        gx_max = GXM1;
        gy_max = GYM1;
        gpr    = GPR1;
        s_max  = COORD_W'(1);
        half   = COORD_W'(1);
      end
      default: begin
        gx_max = GXM2;
        gy_max = GYM2;
        gpr    = GPR2;
        s_max  = COORD_W'(3);
        half   = COORD_W'(2);
      end
    endcase
  end

  assign base_x   = gx_q << r_q;
  assign base_y   = gy_q << r_q;
  assign last_grp = (gx_q == gx_max) && (gy_q == gy_max);
  assign gx_nx    = (gx_q == gx_max) ? '0 : gx_q + 1'b1;
  assign gy_nx    = (gx_q == gx_max) ? gy_q + 1'b1 : gy_q;

`ifdef COARSE_SCHED_COVERAGE_EN
  localparam int NPIX = TILE_W * TILE_H;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic [NPIX-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      mask_q <= cov_mask;
    end
  end

  assign any_cov = |mask_q;

  // A group counts as covered if any pixel whose group coordinate
  // matches (gx,gy) at the current rate is set in the mask.
  always_comb begin
    grp_cov = 1'b0;
    for (int y = 0; y < TILE_H; y++) begin
      for (int x = 0; x < TILE_W; x++) begin
        if (mask_q[IW'(y * TILE_W + x)] &&
            (COORD_W'(x >> r_q) == gx_q) &&
            (COORD_W'(y >> r_q) == gy_q)) begin
          grp_cov = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pix_cov = mask_q[IW'(int'(bus.wr_y) * TILE_W + int'(bus.wr_x))];
  end
`else
  assign any_cov = 1'b1;
  assign grp_cov = 1'b1;
  assign pix_cov = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = (rate_log2 == 2'd3) ? 2'd2 : rate_log2;
          gx_d    = '0;
          gy_d    = '0;
          sx_d    = '0;
          sy_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!any_cov) begin
          state_d = S_DONE;
        end else if (!grp_cov) begin
          // Empty group: step over it without a request.
          if (last_grp) begin
            state_d = S_DONE;
          end else begin
            gx_d = gx_nx;
            gy_d = gy_nx;
          end
        end else if (bus.req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rsp_valid) begin
          data_d  = bus.rsp_data;
          sx_d    = '0;
          sy_d    = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Uncovered pixels advance without a handshake.
        if (bus.wr_ready || !pix_cov) begin
          if (sx_q == s_max) begin
            sx_d = '0;
            if (sy_q == s_max) begin
              sy_d = '0;
              if (last_grp) begin
                state_d = S_DONE;
              end else begin
                gx_d    = gx_nx;
                gy_d    = gy_nx;
                state_d = S_REQ;
              end
            end else begin
              sy_d = sy_q + 1'b1;
            end
          end else begin
            sx_d = sx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs are decoded from registered state only.
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign bus.req_valid    = (state_q == S_REQ) && grp_cov;
  assign bus.req_cen_x    = base_x + half;
  assign bus.req_cen_y    = base_y + half;
  assign bus.req_group_id = gy_q * gpr + gx_q;
  assign bus.rsp_ready    = (state_q == S_WAIT);
  assign bus.wr_valid     = (state_q == S_WRITE) && pix_cov;
  assign bus.wr_x         = base_x + sx_q;
  assign bus.wr_y         = base_y + sy_q;
  assign bus.wr_data      = data_q;

endmodule
